// File: rtl/agc_shift_ctrl_if.sv
// Control/sample bus of the AGC shift controller: the sample stream tap and
// control inputs on one side, the shift coefficient and status on the other.
interface agc_shift_ctrl_if;
    logic        en;
    logic        hold;
    logic        din_valid;
    logic [47:0] din;
    logic [15:0] scaled_coeff;
    logic        coeff_valid;
    logic [5:0]  peak_pos;

    modport master (
        output en, hold, din_valid, din,
        input  scaled_coeff, coeff_valid, peak_pos
    );

    modport slave (
        input  en, hold, din_valid, din,
        output scaled_coeff, coeff_valid, peak_pos
    );
endinterface

// File: rtl/agc_shift_ctrl.sv
// agc_shift_ctrl: tracks the peak magnitude of the 48-bit pre-gain stream over
// a window of 2**WIN_LOG2 valid samples and derives the requantiser left-shift.
module agc_shift_ctrl #(
    parameter int WIN_LOG2   = 10,
    parameter int HEADROOM   = 1,
    parameter int HYST       = 1,
    parameter int SHIFT_MAX  = 32,
    parameter int INIT_SHIFT = 16
) (
    input  logic            clk,
    input  logic            rst,
    agc_shift_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACQ, CALC, UPD} state_t;

    localparam logic [46:0] MAG_SAT = '1;
    localparam int          TBASE   = 46 - HEADROOM;

    state_t              r_state, w_state_nxt;
    logic [47:0]         r_din;
    logic                r_din_vld;
    logic [WIN_LOG2-1:0] r_cnt;
    logic [46:0]         r_peak, r_snap, w_mag;
    logic [47:0]         w_neg;
    logic [5:0]          r_tgt, r_coeff, r_peak_pos, w_tgt, w_p;
    logic                r_cv, w_empty, w_sample, w_win_end, w_apply;
    int                  w_traw;

    // Accumulation runs in every non-IDLE state so CALC/UPD never stall samples.
    assign w_sample  = bus.en && (r_state != IDLE) && r_din_vld;
    assign w_win_end = w_sample && (r_cnt == '1);

    // Magnitude of the registered sample; -2**47 is the only value whose
    // negation stays negative, so it saturates to the largest magnitude.
    always_comb begin
        w_neg = 48'd0 - r_din;
        if (!r_din[47])
            w_mag = r_din[46:0];
        else if (w_neg[47])
            w_mag = MAG_SAT;
        else
            w_mag = w_neg[46:0];
    end

    // Priority-encode the window snapshot and clamp the resulting shift target.
    always_comb begin
        w_p     = 6'd0;
        w_empty = 1'b1;
        for (int i = 0; i < 47; i++) begin
            if (r_snap[i]) begin
                w_p     = 6'(i);
                w_empty = 1'b0;
            end
        end
        w_traw = TBASE - int'(w_p);
        if (w_empty || w_traw > SHIFT_MAX)
            w_tgt = 6'(SHIFT_MAX);
        else if (w_traw < 0)
            w_tgt = 6'd0;
        else
            w_tgt = 6'(w_traw);
    end

    // Decreases always go through; increases only beyond the hysteresis band.
    assign w_apply = (r_state == UPD) && !bus.hold &&
                     ((r_tgt < r_coeff) ||
                      ({1'b0, r_tgt} > ({1'b0, r_coeff} + 7'(HYST))));

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_state_nxt;
    end

    // Next-state logic; dropping en aborts from any state.
    always_comb begin
        w_state_nxt = r_state;
        if (!bus.en) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE:    w_state_nxt = ACQ;
                ACQ:     if (w_win_end) w_state_nxt = CALC;
                CALC:    w_state_nxt = UPD;
                UPD:     w_state_nxt = ACQ;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // Sample capture, window accumulation, target calculation and coefficient update.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_din      <= '0;
            r_din_vld  <= 1'b0;
            r_cnt      <= '0;
            r_peak     <= '0;
            r_snap     <= '0;
            r_tgt      <= '0;
            r_coeff    <= 6'(INIT_SHIFT);
            r_cv       <= 1'b0;
            r_peak_pos <= 6'h3F;
        end else if (!bus.en) begin
            // Window in flight is discarded; coefficient and peak_pos are kept.
            r_din_vld <= 1'b0;
            r_cnt     <= '0;
            r_peak    <= '0;
            r_snap    <= '0;
            r_cv      <= 1'b0;
        end else begin
            r_cv      <= 1'b0;
            r_din     <= bus.din;
            r_din_vld <= (r_state != IDLE) && bus.din_valid;
            if (w_sample) begin
                r_cnt <= r_cnt + 1'b1;
                if (w_win_end) begin
                    r_snap <= r_peak | w_mag;
                    r_peak <= '0;
                end else begin
                    r_peak <= r_peak | w_mag;
                end
            end
            if (r_state == CALC) begin
                r_tgt      <= w_tgt;
                r_peak_pos <= w_empty ? 6'h3F : w_p;
            end
            if (w_apply) begin
                r_coeff <= r_tgt;
                r_cv    <= 1'b1;
            end
        end
    end

    assign bus.scaled_coeff = {10'd0, r_coeff};
    assign bus.coeff_valid  = r_cv;
    assign bus.peak_pos     = r_peak_pos;
endmodule

// File: tb/tb_agc_shift_ctrl.sv
// Bench for agc_shift_ctrl: directed scenarios plus randomized windows checked
// against a window-level reference model (peak magnitude -> MSB -> target).
module tb_agc_shift_ctrl;
    localparam int WL = 4, N = 16, HR = 1, HY = 1, SMAX = 32, INIT = 16;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0, failures = 0, pulse_cnt = 0;
    int   exp_coeff = INIT, exp_pos = 63;
    logic [47:0] win[$];

    agc_shift_ctrl_if u_if();

    agc_shift_ctrl #(.WIN_LOG2(WL), .HEADROOM(HR), .HYST(HY),
                     .SHIFT_MAX(SMAX), .INIT_SHIFT(INIT))
        dut (.clk(clk), .rst(rst), .bus(u_if.slave));

    always #5 clk = ~clk;

    // Counts coefficient-update pulses observed away from the active edge.
    always @(negedge clk) if (u_if.coeff_valid === 1'b1) pulse_cnt++;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: largest saturated magnitude of the window, its MSB index,
    // the clamped target and the hysteresis/hold update decision.
    task automatic model_window(input bit hold, output int pulse);
        longint unsigned mx = 0, m;
        logic [47:0] a;
        int p = -1, t;
        foreach (win[i]) begin
            a = win[i][47] ? (48'd0 - win[i]) : win[i];
            m = 64'(a);
            if (m > 64'h7FFF_FFFF_FFFF) m = 64'h7FFF_FFFF_FFFF;
            if (m > mx) mx = m;
        end
        for (longint unsigned v = mx; v != 0; v = v >> 1) p++;
        t = (p < 0) ? SMAX : (46 - HR - p);
        if (t < 0) t = 0;
        if (t > SMAX) t = SMAX;
        exp_pos = (p < 0) ? 63 : p;
        pulse = 0;
        if (!hold && (t < exp_coeff || t > exp_coeff + HY)) begin
            exp_coeff = t;
            pulse = 1;
        end
    endtask

    task automatic fill(input logic [47:0] v);
        win.delete();
        repeat (N) win.push_back(v);
    endtask

    // Drives the window queue (optionally with invalid beats between samples)
    // and lets the pipeline drain; returns the number of update pulses seen.
    task automatic run_window(input bit gaps, output int pulses);
        int p0 = pulse_cnt;
        foreach (win[i]) begin
            @(negedge clk); u_if.din_valid = 1'b1; u_if.din = win[i];
            if (gaps) begin
                @(negedge clk); u_if.din_valid = 1'b0; u_if.din = 48'h7FFF_FFFF_FFFF;
            end
        end
        @(negedge clk); u_if.din_valid = 1'b0; u_if.din = '0;
        repeat (5) @(negedge clk);
        pulses = pulse_cnt - p0;
    endtask

    task automatic test_reset();
        rst = 1'b0; u_if.en = 1'b0; u_if.hold = 1'b0;
        u_if.din_valid = 1'b0; u_if.din = '0;
        repeat (3) @(negedge clk);
        checks++; if (u_if.scaled_coeff !== 16'(INIT))
            begin failures++; $display("FAIL reset_coeff got=%0d want=%0d", u_if.scaled_coeff, INIT); end
        checks++; if (u_if.coeff_valid !== 1'b0)
            begin failures++; $display("FAIL reset_cv got=%b want=0", u_if.coeff_valid); end
        checks++; if (u_if.peak_pos !== 6'h3F)
            begin failures++; $display("FAIL reset_pos got=%h want=3f", u_if.peak_pos); end
        rst = 1'b1; u_if.en = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic_latency();
        logic cv_exp [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        int p0, ep;
        fill(48'h0001_0000_0000);
        p0 = pulse_cnt;
        foreach (win[i]) begin
            @(negedge clk); u_if.din_valid = 1'b1; u_if.din = win[i];
        end
        @(negedge clk); u_if.din_valid = 1'b0; u_if.din = '0;
        checks++; if (u_if.peak_pos !== 6'h3F)
            begin failures++; $display("FAIL basic_pos_early got=%h want=3f", u_if.peak_pos); end
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            checks++; if (u_if.coeff_valid !== cv_exp[k])
                begin failures++; $display("FAIL basic_cv_t%0d got=%b want=%b", k, u_if.coeff_valid, cv_exp[k]); end
        end
        model_window(1'b0, ep);
        checks++; if (u_if.scaled_coeff !== 16'd13 || exp_coeff != 13)
            begin failures++; $display("FAIL basic_coeff got=%0d want=13 model=%0d", u_if.scaled_coeff, exp_coeff); end
        checks++; if (u_if.peak_pos !== 6'd32)
            begin failures++; $display("FAIL basic_pos got=%0d want=32", u_if.peak_pos); end
        checks++; if (pulse_cnt - p0 != 1 || ep != 1)
            begin failures++; $display("FAIL basic_pulses got=%0d want=1", pulse_cnt - p0); end
    endtask

    task automatic test_clamp();
        int n, ep;
        fill(48'h8000_0000_0000);
        run_window(1'b0, n); model_window(1'b0, ep);
        checks++; if (u_if.scaled_coeff !== 16'd0 || u_if.peak_pos !== 6'd46 || n != 1)
            begin failures++; $display("FAIL clamp_min coeff=%0d pos=%0d pulses=%0d want 0/46/1", u_if.scaled_coeff, u_if.peak_pos, n); end
        fill(48'h0);
        run_window(1'b0, n); model_window(1'b0, ep);
        checks++; if (u_if.scaled_coeff !== 16'(SMAX) || u_if.peak_pos !== 6'h3F || n != 1)
            begin failures++; $display("FAIL clamp_empty coeff=%0d pos=%h pulses=%0d want 32/3f/1", u_if.scaled_coeff, u_if.peak_pos, n); end
    endtask

    task automatic test_hysteresis();
        int ps   [4] = '{32, 31, 30, 33};
        int want [4] = '{13, 13, 15, 12};
        int wp   [4] = '{1, 0, 1, 1};
        int n, ep;
        for (int k = 0; k < 4; k++) begin
            fill(48'd1 << ps[k]);
            run_window(1'b0, n); model_window(1'b0, ep);
            checks++; if (u_if.scaled_coeff !== 16'(want[k]) || n != wp[k] || exp_coeff != want[k])
                begin failures++; $display("FAIL hyst_p%0d coeff=%0d pulses=%0d want %0d/%0d", ps[k], u_if.scaled_coeff, n, want[k], wp[k]); end
        end
    endtask

    task automatic test_hold();
        int n, ep;
        u_if.hold = 1'b1;
        for (int k = 0; k < 2; k++) begin
            fill(k == 0 ? (48'd1 << 20) : (48'd0 - (48'd1 << 20)));
            run_window(1'b0, n); model_window(1'b1, ep);
            checks++; if (u_if.peak_pos !== 6'd20 || u_if.scaled_coeff !== 16'd12 || n != 0)
                begin failures++; $display("FAIL hold_w%0d pos=%0d coeff=%0d pulses=%0d want 20/12/0", k, u_if.peak_pos, u_if.scaled_coeff, n); end
        end
        u_if.hold = 1'b0;
        fill(48'd1 << 20);
        run_window(1'b0, n); model_window(1'b0, ep);
        checks++; if (u_if.scaled_coeff !== 16'd25 || n != 1)
            begin failures++; $display("FAIL hold_release coeff=%0d pulses=%0d want 25/1", u_if.scaled_coeff, n); end
    endtask

    task automatic test_gaps();
        int n, ep;
        fill(48'h0001_0000_0000);
        run_window(1'b1, n); model_window(1'b0, ep);
        checks++; if (u_if.scaled_coeff !== 16'd13 || u_if.peak_pos !== 6'd32 || n != 1)
            begin failures++; $display("FAIL gaps coeff=%0d pos=%0d pulses=%0d want 13/32/1", u_if.scaled_coeff, u_if.peak_pos, n); end
    endtask

    task automatic drive_n(input int cnt, input logic [47:0] v);
        for (int i = 0; i < cnt; i++) begin
            @(negedge clk); u_if.din_valid = 1'b1; u_if.din = v;
        end
        @(negedge clk); u_if.din_valid = 1'b0; u_if.din = '0;
    endtask

    task automatic test_enable_reset();
        int p0, ep;
        p0 = pulse_cnt;
        drive_n(9, 48'h8000_0000_0000);
        u_if.en = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if (u_if.scaled_coeff !== 16'd13 || u_if.peak_pos !== 6'd32 || pulse_cnt != p0)
            begin failures++; $display("FAIL en_abort coeff=%0d pos=%0d pulses=%0d want 13/32/0", u_if.scaled_coeff, u_if.peak_pos, pulse_cnt - p0); end
        u_if.en = 1'b1;
        repeat (2) @(negedge clk);
        drive_n(15, 48'd1 << 20);
        repeat (6) @(negedge clk);
        checks++; if (u_if.scaled_coeff !== 16'd13 || pulse_cnt != p0)
            begin failures++; $display("FAIL en_fresh_window coeff=%0d pulses=%0d want 13/0", u_if.scaled_coeff, pulse_cnt - p0); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        exp_coeff = INIT; exp_pos = 63;
        checks++; if (u_if.scaled_coeff !== 16'(INIT) || u_if.peak_pos !== 6'h3F || u_if.coeff_valid !== 1'b0)
            begin failures++; $display("FAIL midwin_reset coeff=%0d pos=%h cv=%b want 16/3f/0", u_if.scaled_coeff, u_if.peak_pos, u_if.coeff_valid); end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        p0 = pulse_cnt;
        drive_n(15, 48'd1 << 20);
        repeat (6) @(negedge clk);
        checks++; if (u_if.scaled_coeff !== 16'(INIT) || pulse_cnt != p0)
            begin failures++; $display("FAIL reset_15_samples coeff=%0d pulses=%0d want 16/0", u_if.scaled_coeff, pulse_cnt - p0); end
        drive_n(1, 48'd1 << 20);
        repeat (6) @(negedge clk);
        fill(48'd1 << 20); model_window(1'b0, ep);
        checks++; if (u_if.scaled_coeff !== 16'(exp_coeff) || u_if.peak_pos !== 6'd20 || pulse_cnt - p0 != ep)
            begin failures++; $display("FAIL reset_16th coeff=%0d pos=%0d pulses=%0d want %0d/20/%0d", u_if.scaled_coeff, u_if.peak_pos, pulse_cnt - p0, exp_coeff, ep); end
    endtask

    task automatic test_back_to_back();
        logic [47:0] q1[$], q2[$];
        int n, e1, e2;
        win.delete();
        repeat (N) q1.push_back(48'd1 << 40);
        repeat (N) q2.push_back(48'd0 - (48'd1 << 10));
        win = q1; model_window(1'b0, e1);
        win = q2; model_window(1'b0, e2);
        win = {q1, q2};
        run_window(1'b0, n);
        checks++; if (u_if.scaled_coeff !== 16'(exp_coeff) || u_if.peak_pos !== 6'(exp_pos) || n != e1 + e2)
            begin failures++; $display("FAIL back_to_back coeff=%0d pos=%0d pulses=%0d want %0d/%0d/%0d", u_if.scaled_coeff, u_if.peak_pos, n, exp_coeff, exp_pos, e1 + e2); end
    endtask

    task automatic test_random();
        logic [63:0] r;
        logic [47:0] v;
        bit hold, gaps, zero;
        int n, ep;
        for (int w = 0; w < 24; w++) begin
            hold = ($urandom_range(0, 3) == 0);
            gaps = $urandom_range(0, 1);
            zero = ($urandom_range(0, 7) == 0);
            win.delete();
            for (int i = 0; i < N; i++) begin
                r = {$urandom(), $urandom()};
                v = r[47:0] >> $urandom_range(0, 47);
                if ($urandom_range(0, 1)) v = 48'd0 - v;
                if ($urandom_range(0, 40) == 0) v = 48'h8000_0000_0000;
                win.push_back(zero ? 48'd0 : v);
            end
            u_if.hold = hold;
            run_window(gaps, n); model_window(hold, ep);
            checks++; if (u_if.scaled_coeff !== 16'(exp_coeff) || u_if.peak_pos !== 6'(exp_pos) || n != ep)
                begin failures++; $display("FAIL random_w%0d coeff=%0d pos=%0d pulses=%0d want %0d/%0d/%0d", w, u_if.scaled_coeff, u_if.peak_pos, n, exp_coeff, exp_pos, ep); end
        end
        u_if.hold = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic_latency();
        test_clamp();
        test_hysteresis();
        test_hold();
        test_gaps();
        test_enable_reset();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
